// File: rtl/dat_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : dat_mem_arb
// Purpose  : Round-robin arbiter in front of a single-port data memory.
//            Grants at most one requester per cycle (combinational), drives
//            the memory port, and returns registered read data one cycle later.
// Options  : DAT_MEM_ARB_LOCK_EN - adds req_lock; a granted transfer with
//            lock set keeps the memory owned by that requester until it
//            issues a granted transfer with lock clear.
// Revision : 1.0 - initial release
// ============================================================================
module dat_mem_arb #(
  parameter int NREQ = 2,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
`ifdef DAT_MEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]  req_lock,
`endif
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_wr_en,
  output logic [DW-1:0]    mem_dat_in,
  input  logic [DW-1:0]    mem_dat_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_rr_ptr;
  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [PW-1:0]   w_win_idx;
  logic [PW-1:0]   w_next_ptr;
  logic            w_win_lock;
  logic            w_win_we;

`ifdef DAT_MEM_ARB_LOCK_EN
  logic            r_locked;
  logic [PW-1:0]   r_lock_own;

  // While locked only the owner is eligible; everyone else sees no ready
  always_comb begin
    w_elig = r_locked ? (req_valid & (NREQ'(1) << r_lock_own)) : req_valid;
  end

  assign w_win_lock = req_lock[w_win_idx];
`else
  assign w_elig     = req_valid;
  assign w_win_lock = 1'b0;
`endif

  // Scan eligible requesters starting at the round-robin pointer
  always_comb begin
    int idx;
    w_found   = 1'b0;
    w_win_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && w_elig[idx]) begin
        w_found   = 1'b1;
        w_win_idx = PW'(idx);
      end
    end
  end

  assign w_win_we   = req_we[w_win_idx];
  assign w_next_ptr = (int'(w_win_idx) == NREQ - 1) ? '0 : w_win_idx + PW'(1);

  // Grant vector and memory port; everything is zero when nobody wins so
  // that a stray req_we can never reach the memory
  always_comb begin
    req_ready  = '0;
    mem_addr   = '0;
    mem_wr_en  = 1'b0;
    mem_dat_in = '0;
    if (w_found) begin
      req_ready  = NREQ'(1) << w_win_idx;
      mem_addr   = req_addr[w_win_idx*AW +: AW];
      mem_wr_en  = w_win_we;
      mem_dat_in = req_wdata[w_win_idx*DW +: DW];
    end
  end

  // Read response: one-cycle pulse to the winner, data held until next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (w_found && !w_win_we) begin
        rsp_valid <= NREQ'(1) << w_win_idx;
        rsp_rdata <= mem_dat_out;
      end
    end
  end

  // Pointer moves past the winner unless the winner is taking/keeping a lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_found && !w_win_lock) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

`ifdef DAT_MEM_ARB_LOCK_EN
  // Lock ownership: set by a locked grant, cleared by the owner's unlocked grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked   <= 1'b0;
      r_lock_own <= '0;
    end else if (w_found) begin
      if (w_win_lock) begin
        r_locked   <= 1'b1;
        r_lock_own <= w_win_idx;
      end else begin
        r_locked   <= 1'b0;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dat_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dat_mem_arb
// Purpose  : Directed self-checking bench for dat_mem_arb (NREQ=2) with a
//            behavioural 256x8 memory attached to the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dat_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_lock;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [7:0]  mem_addr;
  logic        mem_wr_en;
  logic [7:0]  mem_dat_in;
  logic [7:0]  mem_dat_out;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];

  dat_mem_arb #(.NREQ(2), .AW(8), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DAT_MEM_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_dat_in (mem_dat_in),
    .mem_dat_out(mem_dat_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: synchronous write, combinational read
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
  end
  assign mem_dat_out = mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, required finish");
    $fatal(1, "timeout");
  end

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [7:0] a, input logic [7:0] d, input logic lk);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_addr[i*8 +: 8]   = a;
    req_wdata[i*8 +: 8]  = d;
    req_lock[i]          = lk;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_lock = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rsp_rdata); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    checks++; if (mem_dat_in !== 8'h00) begin errors++; $display("FAIL reset_dat_in: got %h want 00", mem_dat_in); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Both requesters read continuously; pointer starts at 0 after reset
  task automatic test_back_to_back();
    logic [1:0] exp_rdy [4];
    logic [7:0] exp_dat [4];
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
    exp_dat[0] = 8'h11; exp_dat[1] = 8'h22; exp_dat[2] = 8'h11; exp_dat[3] = 8'h22;
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== exp_rdy[k]) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy[k]); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== exp_rdy[k]) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b want %b", k, rsp_valid, exp_rdy[k]); end
      checks++; if (rsp_rdata !== exp_dat[k]) begin errors++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, rsp_rdata, exp_dat[k]); end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  // Requester 0 writes 0xA5 to 0x10 then reads it back
  task automatic test_write_read();
    set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL wr_en: got %b want 1", mem_wr_en); end
    checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL wr_addr: got %h want 10", mem_addr); end
    checks++; if (mem_dat_in !== 8'hA5) begin errors++; $display("FAIL wr_dat_in: got %h want a5", mem_dat_in); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_no_rsp: got %b want 00", rsp_valid); end
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rd_wr_en: got %b want 0", mem_wr_en); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (rsp_rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata: got %h want a5", rsp_rdata); end
    @(negedge clk);
    clear_reqs();
  endtask

  // Reset asserted mid-cycle after a read grant drops the response and the pointer
  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_ready: got %b want 01", req_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL mid_async_rdata: got %h want 00", rsp_rdata); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_rsp_dropped: got %b want 00", rsp_valid); end
    @(negedge clk);
    clear_reqs();
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_ready: got %b want 01", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_rdata !== 8'h11) begin errors++; $display("FAIL post_reset_rdata: got %h want 11", rsp_rdata); end
    @(negedge clk);
    clear_reqs();
  endtask

  // Top address: requester 1 writes 0x7F to 0xFF then reads it back
  task automatic test_top_addr();
    set_req(1, 1'b1, 1'b1, 8'hFF, 8'h7F, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL top_wr_ready: got %b want 10", req_ready); end
    checks++; if (mem_addr !== 8'hFF) begin errors++; $display("FAIL top_wr_addr: got %h want ff", mem_addr); end
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL top_rsp_valid: got %b want 10", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h7F) begin errors++; $display("FAIL top_rdata: got %h want 7f", rsp_rdata); end
    @(negedge clk);
    clear_reqs();
  endtask

  // No valid requests, but noisy we/addr/data fields: nothing may leak out
  task automatic test_idle();
    req_we = 2'b11; req_addr = 16'h3344; req_wdata = 16'h5566;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_ready[%0d]: got %b want 00", k, req_ready); end
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en[%0d]: got %b want 0", k, mem_wr_en); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL idle_rsp_valid[%0d]: got %b want 00", k, rsp_valid); end
      checks++; if (rsp_rdata !== 8'h7F) begin errors++; $display("FAIL idle_rdata[%0d]: got %h want 7f", k, rsp_rdata); end
      @(negedge clk);
    end
    clear_reqs();
  endtask

`ifdef DAT_MEM_ARB_LOCK_EN
  // Requester 1 locks for a read-modify-write while requester 0 keeps asking
  task automatic test_lock();
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); @(negedge clk);
    set_req(1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_rd_ready: got %b want 10", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_rdata !== 8'h33) begin errors++; $display("FAIL lock_rd_rdata: got %h want 33", rsp_rdata); end
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL lock_block_ready: got %b want 00", req_ready); end
    @(posedge clk); @(negedge clk);
    set_req(1, 1'b1, 1'b1, 8'h20, 8'h34, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_wr_ready: got %b want 10", req_ready); end
    @(posedge clk); @(negedge clk);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lock_release_ready: got %b want 01", req_ready); end
    @(posedge clk); @(negedge clk);
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    @(posedge clk); #1;
    checks++; if (rsp_rdata !== 8'h34) begin errors++; $display("FAIL lock_rmw_rdata: got %h want 34", rsp_rdata); end
    @(negedge clk);
    clear_reqs();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11;
    mem[8'h01] = 8'h22;
    mem[8'h20] = 8'h33;
    rst_n = 1'b0;
    clear_reqs();
    test_reset();
    test_back_to_back();
    test_write_read();
    test_reset_mid();
    test_top_addr();
    test_idle();
`ifdef DAT_MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dat_mem_arb.md
# dat_mem_arb

Round-robin arbiter that shares the single-port 8-bit × 256 data memory between `NREQ` requesters, such as the core load/store unit and the stack push/pop engine. It sits directly in front of the memory. Each cycle it grants at most one request, drives the memory's address, write-enable and write data, and returns registered read data to the winning requester one cycle later.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..8)
- `AW`, 8, address width (memory depth 2^AW)
- `DW`, 8, data width

Ports:
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in `NREQ`: request pending, one bit per requester
- `req_we` in `NREQ`: 1 = write, 0 = read
- `req_addr` in `NREQ*AW`: packed addresses; requester i uses bits `[i*AW +: AW]`
- `req_wdata` in `NREQ*DW`: packed write data
- `req_lock` in `NREQ`: hold grant after this transfer; present only with `DAT_MEM_ARB_LOCK_EN`
- `req_ready` out `NREQ`: one-hot grant; the transfer is accepted this cycle
- `rsp_valid` out `NREQ`: read data valid, a one-cycle pulse
- `rsp_rdata` out `DW`: read data, shared by all requesters
- `mem_addr` out `AW`: to memory address
- `mem_wr_en` out 1: to memory write enable
- `mem_dat_in` out `DW`: to memory write data
- `mem_dat_out` in `DW`: combinational read data from memory

## Operation
- Round-robin pointer `rr_ptr` (`$clog2(NREQ)` bits), reset to 0.
- Grant selection is combinational. The winner is the first requester i with `req_valid[i]` = 1, scanning i = `rr_ptr`, `rr_ptr`+1, … modulo `NREQ`.
- `req_ready` is one-hot on the winner and all-zero when no `req_valid` bit is set. A transfer completes when valid and ready are both 1.
- Memory drive:
  - Winner present: `mem_addr` = winner's address. `mem_wr_en` = winner's `req_we`. `mem_dat_in` = winner's `req_wdata`.
  - No winner: `mem_addr` = 0, `mem_wr_en` = 0, `mem_dat_in` = 0. No write ever occurs without a grant.
- Read grant: on the next edge, `rsp_rdata` <= `mem_dat_out` and `rsp_valid[winner]` <= 1. All other `rsp_valid` bits <= 0.
- Write grant: no response. `rsp_valid` <= 0 and `rsp_rdata` holds its value.
- `rsp_rdata` holds the last read value until the next read grant.
- After any grant to requester i: `rr_ptr` <= (i+1) mod `NREQ`. With no grant, `rr_ptr` holds.
- A requester must keep `req_valid` and its fields stable until it sees `req_ready`. The arbiter does not buffer requests.
- Simultaneous requests: exactly one is granted. A continuously asserting requester is granted within `NREQ` cycles.
- Reset (async, any time):
  - `rr_ptr` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, lock released.
  - Any in-flight read response is dropped.
  - Combinational outputs follow inputs, with `rr_ptr` = 0.

## Timing
- Request to grant: 0 cycles (combinational valid→ready path).
- Write: memory is updated at the edge ending the grant cycle.
- Read: `rsp_valid` and `rsp_rdata` appear the cycle after the grant, i.e. 1-cycle latency.
- Throughput: one transfer per cycle, back-to-back across requesters or from the same requester.
- Read-after-write to the same address in consecutive grants returns the new data, because the write lands before the next combinational read.
- Reset values: `req_ready` = 0 (with no valid), `rsp_valid` = 0, `rsp_rdata` = 0, `mem_wr_en` = 0, `mem_addr` = 0, `mem_dat_in` = 0.

## Configuration
`DAT_MEM_ARB_LOCK_EN`:
- Defined:
  - `req_lock` exists.
  - A granted transfer with `req_lock[i]` = 1 sets `lock_own` = i, `locked` = 1.
  - While `locked`, only requester `lock_own` can be granted; other requesters see `req_ready` = 0.
  - The lock clears at the edge of a granted transfer from `lock_own` with `req_lock` = 0.
  - `rr_ptr` does not advance while locked and advances normally on the releasing grant.
  - This supports atomic read-modify-write and multi-byte pushes.
- Undefined:
  - No `req_lock` port and no lock state.
  - Pure round-robin arbitration.

## Test plan
- Reset, then requester 0 writes 0xA5 to 0x10, then reads 0x10 → `rsp_valid` = 01 one cycle after the read grant, `rsp_rdata` = 0xA5.
- Both requesters hold reads at 0x00/0x01 (contents 0x11/0x22) for 4 cycles → grants alternate 01,10,01,10; responses 0x11,0x22,0x11,0x22, each one cycle late.
- No `req_valid` for 5 cycles → `mem_wr_en` = 0, `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` holds its last value.
- Assert `rst_n` = 0 mid-cycle after a read grant → `rsp_valid` stays 0. After release, requester 0 wins first, since `rr_ptr` = 0.
- `DAT_MEM_ARB_LOCK_EN`: requester 1 reads 0x20 with lock, then writes 0x20 with lock = 0, while requester 0 requests continuously → requester 0 gets no ready until the write completes, then it is granted next.
- Write 0x7F to 0xFF then read 0xFF back-to-back → read returns 0x7F; top address decodes correctly.
